issue_queue_dual: RTL and testbench
===================================

// Module: issue_queue_dual
// PURPOSE
//  In-order issue queue between decode and the issue/EX1 pipeline register.
//  Buffers decoded instructions in a circular FIFO and presents the two oldest
//  entries as slot 1 and slot 2. Decides each cycle whether to issue 0, 1 or 2
//  instructions, and drives nop1/nop2 to the issue/EX1 register.
// PARAMETERS
//  DEPTH  8  queue entries; power of 2, >=4; pointer width = $clog2(DEPTH)
// PORTS
//  clk             in   1   clock
//  rstn            in   1   reset, asynchronous, active-low
//  flush_signal1   in   1   branch/jump redirect from ALU pipe 1; empties queue
//  flush_signal2   in   1   branch/jump redirect from ALU pipe 2; empties queue
//  stall           in   1   downstream hold; no dequeue this cycle
//  in_valid1       in   1   decode slot 1 valid (older)
//  in_valid2       in   1   decode slot 2 valid; ignored unless in_valid1=1
//  in_ready        out  1   queue has >=2 free entries (from current count)
//  in_instrN       in   32  raw instruction, N=1,2
//  in_instrN_imm   in   32  decoded immediate, N=1,2
//  in_instrN_rs1/rs2/rd_address  in  5 each  register indices, N=1,2
//  in_instrN_pc    in   32  instruction PC, N=1,2
//  in_instrN_bp    in   1   branch predict state, N=1,2
//  out_instrN, out_instrN_imm, out_instrN_rs1/rs2/rd_address, out_instrN_pc,
//  out_instrN_bp   out  same widths   head (N=1) / head+1 (N=2) entry fields
//  nop1            out  1   slot 1 not issued this cycle
//  nop2            out  1   slot 2 not issued this cycle
// BEHAVIOUR
//  Reset: head=tail=count=0; in_ready=1; nop1=nop2=1; all out_* = 0.
//   Entry storage is not reset.
//  Enqueue: when in_valid1 && in_ready && !flush, write slot 1 at tail; also
//   slot 2 at tail+1 if in_valid2. tail advances by 1 or 2 (mod DEPTH).
//  Issue decision is combinational from registered queue state:
//   - v1 = count>=1; v2 = count>=2.
//   - hazard = slot1.rd!=0 && (slot2.rs1==slot1.rd || slot2.rs2==slot1.rd).
//   - mem-pair = both opcodes in {0000011, 0100011}.
//   - ctrl1 = slot1 opcode in {1100011, 1101111, 1100111}.
//   - issue1 = v1 && !stall.
//   - issue2 = issue1 && v2 && !hazard && !mem-pair && !ctrl1.
//   - nop1 = !v1; nop2 = !(v2 && !hazard && !mem-pair && !ctrl1).
//     Independent of stall; the issue/EX1 register gives stall priority.
//  Outputs: out_instrN_* = entry fields when slot N is valid and its nop is 0,
//   else 0. This matches the zeroing done by issue/EX1.
//  Dequeue: head += issue1+issue2 (mod DEPTH).
//   count_next = count + enq_cnt - deq_cnt.
//  Enqueue, dequeue and pointer wrap may coincide in the same cycle.
//   Slots freed by a dequeue raise in_ready only on the next cycle.
//   No bypass: an entry written into an empty queue is visible next cycle.
//  Flush (either flush signal) is synchronous: head=tail=count=0 next cycle.
//   Flush has priority over enqueue and dequeue in the same cycle.
//  Reset mid-operation clears pointers immediately (async); queue is empty.
//  Invariant: count never exceeds DEPTH; an enqueue while !in_ready is dropped.
// CONFIGURATION
//  ISSUE_QUEUE_PERF_EN defined:
//   - adds out ports dual_issue_cnt[31:0] and single_issue_cnt[31:0].
//   - dual_issue_cnt increments on cycles with issue2; single_issue_cnt on
//     issue1 && !issue2. Both wrap at 2^32.
//   - both clear on reset only, not on flush.
//  ISSUE_QUEUE_PERF_EN undefined: these ports and counters do not exist.
// TESTING
//  1 Reset, then 3 idle cycles -> in_ready=1, nop1=nop2=1, all out_*=0.
//  2 Enqueue addi x1 @pc 0x0 and addi x2 @pc 0x4 (independent)
//    -> next cycle nop1=0, nop2=0, out_instr2_pc=0x4; count goes 2->0.
//  3 Enqueue addi x3,x0,1 then add x4,x3,x3 (RAW)
//    -> first cycle nop2=1, only slot 1 issues.
//    -> next cycle the add issues as slot 1 with nop2=1.
//  4 Fill 8 entries with 2-wide enqueues while stall=1 -> in_ready=0 at
//    count=7 and 8; extra in_valid1 is dropped; head/tail wrap correctly
//    after 6 further enqueue/dequeue cycles.
//  5 count=5 with flush_signal2=1 and in_valid1=1 in the same cycle
//    -> next cycle count=0, nop1=1; the in-flight enqueue is discarded.
//  6 Slot 1 = beq, slot 2 = lw (and separately lw + sw pair)
//    -> nop2=1 in both cases; with ISSUE_QUEUE_PERF_EN defined,
//       single_issue_cnt increments by 1 per such cycle.

Source files
------------

// File: rtl/issue_queue_dual.sv
// In-order dual-issue queue between decode and the issue/EX1 register.
// Define ISSUE_QUEUE_PERF_EN to add dual/single issue performance counters.
module issue_queue_dual #(
   parameter int unsigned DEPTH = 8
) (
   input  logic        clk,
   input  logic        rstn,
`ifdef ISSUE_QUEUE_PERF_EN
   output logic [31:0] dual_issue_cnt,
   output logic [31:0] single_issue_cnt,
`endif
   input  logic        flush_signal1,
   input  logic        flush_signal2,
   input  logic        stall,
   input  logic        in_valid1,
   input  logic        in_valid2,
   output logic        in_ready,
   input  logic [31:0] in_instr1,
   input  logic [31:0] in_instr1_imm,
   input  logic [4:0]  in_instr1_rs1_address,
   input  logic [4:0]  in_instr1_rs2_address,
   input  logic [4:0]  in_instr1_rd_address,
   input  logic [31:0] in_instr1_pc,
   input  logic        in_instr1_bp,
   input  logic [31:0] in_instr2,
   input  logic [31:0] in_instr2_imm,
   input  logic [4:0]  in_instr2_rs1_address,
   input  logic [4:0]  in_instr2_rs2_address,
   input  logic [4:0]  in_instr2_rd_address,
   input  logic [31:0] in_instr2_pc,
   input  logic        in_instr2_bp,
   output logic [31:0] out_instr1,
   output logic [31:0] out_instr1_imm,
   output logic [4:0]  out_instr1_rs1_address,
   output logic [4:0]  out_instr1_rs2_address,
   output logic [4:0]  out_instr1_rd_address,
   output logic [31:0] out_instr1_pc,
   output logic        out_instr1_bp,
   output logic [31:0] out_instr2,
   output logic [31:0] out_instr2_imm,
   output logic [4:0]  out_instr2_rs1_address,
   output logic [4:0]  out_instr2_rs2_address,
   output logic [4:0]  out_instr2_rd_address,
   output logic [31:0] out_instr2_pc,
   output logic        out_instr2_bp,
   output logic        nop1,
   output logic        nop2
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic        bp;
   } entry_t;

   entry_t        mem [DEPTH];
   logic [PW-1:0] head, tail;
   logic [CW-1:0] count;

   entry_t        in1, in2, s1, s2;
   logic          flush, enq, v1, v2, hazard, mem_pair, ctrl1, pair_ok;
   logic          issue1, issue2;
   logic [1:0]    enq_cnt, deq_cnt;

   function automatic logic is_mem(input logic [6:0] op);
      return (op == 7'b0000011) || (op == 7'b0100011);
   endfunction

   function automatic logic is_ctrl(input logic [6:0] op);
      return (op == 7'b1100011) || (op == 7'b1101111) || (op == 7'b1100111);
   endfunction

   assign in1 = '{in_instr1, in_instr1_imm, in_instr1_rs1_address, in_instr1_rs2_address,
                  in_instr1_rd_address, in_instr1_pc, in_instr1_bp};
   assign in2 = '{in_instr2, in_instr2_imm, in_instr2_rs1_address, in_instr2_rs2_address,
                  in_instr2_rd_address, in_instr2_pc, in_instr2_bp};

   assign s1 = mem[head];
   assign s2 = mem[head + PW'(1)];

   assign flush    = flush_signal1 | flush_signal2;
   assign in_ready = (count <= CW'(DEPTH - 2));
   assign enq      = in_valid1 & in_ready & ~flush;
   assign enq_cnt  = enq ? (in_valid2 ? 2'd2 : 2'd1) : 2'd0;

   assign v1       = (count != '0);
   assign v2       = (count >= CW'(2));
   assign hazard   = (s1.rd != 5'd0) && ((s2.rs1 == s1.rd) || (s2.rs2 == s1.rd));
   assign mem_pair = is_mem(s1.instr[6:0]) & is_mem(s2.instr[6:0]);
   assign ctrl1    = is_ctrl(s1.instr[6:0]);
   assign pair_ok  = v2 & ~hazard & ~mem_pair & ~ctrl1;

   // nop flags ignore stall; the issue/EX1 register applies stall itself
   assign nop1     = ~v1;
   assign nop2     = ~pair_ok;
   assign issue1   = v1 & ~stall;
   assign issue2   = issue1 & pair_ok;
   assign deq_cnt  = 2'(issue1) + 2'(issue2);

   always_comb begin
      {out_instr1, out_instr1_imm, out_instr1_rs1_address, out_instr1_rs2_address,
       out_instr1_rd_address, out_instr1_pc, out_instr1_bp} = '0;
      {out_instr2, out_instr2_imm, out_instr2_rs1_address, out_instr2_rs2_address,
       out_instr2_rd_address, out_instr2_pc, out_instr2_bp} = '0;
      if (!nop1)
         {out_instr1, out_instr1_imm, out_instr1_rs1_address, out_instr1_rs2_address,
          out_instr1_rd_address, out_instr1_pc, out_instr1_bp} = s1;
      if (!nop2)
         {out_instr2, out_instr2_imm, out_instr2_rs1_address, out_instr2_rs2_address,
          out_instr2_rd_address, out_instr2_pc, out_instr2_bp} = s2;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PW'(deq_cnt);
         tail  <= tail + PW'(enq_cnt);
         count <= count + CW'(enq_cnt) - CW'(deq_cnt);
      end
   end

   // Entry storage is deliberately left unreset
   always_ff @(posedge clk) begin
      if (enq) begin
         mem[tail] <= in1;
         if (in_valid2)
            mem[tail + PW'(1)] <= in2;
      end
   end

`ifdef ISSUE_QUEUE_PERF_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         dual_issue_cnt   <= '0;
         single_issue_cnt <= '0;
      end else begin
         if (issue2)
            dual_issue_cnt <= dual_issue_cnt + 32'd1;
         if (issue1 && !issue2)
            single_issue_cnt <= single_issue_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_issue_queue_dual.sv
// Scoreboard bench for issue_queue_dual: accepted entries are queued and
// checked against slot outputs in order; honours ISSUE_QUEUE_PERF_EN.
module tb_issue_queue_dual;

   localparam int unsigned DEPTH = 8;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] imm;
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        bp;
   } ent_t;

   logic        clk = 1'b0;
   logic        rstn;
   logic        flush_signal1, flush_signal2, stall, in_valid1, in_valid2, in_ready;
   logic [31:0] in_instr1, in_instr1_imm, in_instr1_pc, in_instr2, in_instr2_imm, in_instr2_pc;
   logic [4:0]  in_instr1_rs1_address, in_instr1_rs2_address, in_instr1_rd_address;
   logic [4:0]  in_instr2_rs1_address, in_instr2_rs2_address, in_instr2_rd_address;
   logic        in_instr1_bp, in_instr2_bp;
   logic [31:0] out_instr1, out_instr1_imm, out_instr1_pc, out_instr2, out_instr2_imm, out_instr2_pc;
   logic [4:0]  out_instr1_rs1_address, out_instr1_rs2_address, out_instr1_rd_address;
   logic [4:0]  out_instr2_rs1_address, out_instr2_rs2_address, out_instr2_rd_address;
   logic        out_instr1_bp, out_instr2_bp, nop1, nop2;
`ifdef ISSUE_QUEUE_PERF_EN
   logic [31:0] dual_issue_cnt, single_issue_cnt;
`endif

   int unsigned n_checks = 0;
   int unsigned n_fails  = 0;
   int unsigned exp_dual = 0;
   int unsigned exp_single = 0;
   logic [31:0] pc_ctr = '0;
   ent_t        sb[$];
   ent_t        cur1, cur2;

   always #5 clk = ~clk;

   issue_queue_dual #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rstn(rstn),
`ifdef ISSUE_QUEUE_PERF_EN
      .dual_issue_cnt(dual_issue_cnt), .single_issue_cnt(single_issue_cnt),
`endif
      .flush_signal1(flush_signal1), .flush_signal2(flush_signal2), .stall(stall),
      .in_valid1(in_valid1), .in_valid2(in_valid2), .in_ready(in_ready),
      .in_instr1(in_instr1), .in_instr1_imm(in_instr1_imm),
      .in_instr1_rs1_address(in_instr1_rs1_address), .in_instr1_rs2_address(in_instr1_rs2_address),
      .in_instr1_rd_address(in_instr1_rd_address), .in_instr1_pc(in_instr1_pc), .in_instr1_bp(in_instr1_bp),
      .in_instr2(in_instr2), .in_instr2_imm(in_instr2_imm),
      .in_instr2_rs1_address(in_instr2_rs1_address), .in_instr2_rs2_address(in_instr2_rs2_address),
      .in_instr2_rd_address(in_instr2_rd_address), .in_instr2_pc(in_instr2_pc), .in_instr2_bp(in_instr2_bp),
      .out_instr1(out_instr1), .out_instr1_imm(out_instr1_imm),
      .out_instr1_rs1_address(out_instr1_rs1_address), .out_instr1_rs2_address(out_instr1_rs2_address),
      .out_instr1_rd_address(out_instr1_rd_address), .out_instr1_pc(out_instr1_pc), .out_instr1_bp(out_instr1_bp),
      .out_instr2(out_instr2), .out_instr2_imm(out_instr2_imm),
      .out_instr2_rs1_address(out_instr2_rs1_address), .out_instr2_rs2_address(out_instr2_rs2_address),
      .out_instr2_rd_address(out_instr2_rd_address), .out_instr2_pc(out_instr2_pc), .out_instr2_bp(out_instr2_bp),
      .nop1(nop1), .nop2(nop2)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] i_addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, 7'b0010011};
   endfunction
   function automatic logic [31:0] i_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] i_lw(input logic [4:0] rd, input logic [4:0] rs1);
      return {12'h010, rs1, 3'b010, rd, 7'b0000011};
   endfunction
   function automatic logic [31:0] i_sw(input logic [4:0] rs2, input logic [4:0] rs1);
      return {7'b0, rs2, rs1, 3'b010, 5'b01000, 7'b0100011};
   endfunction
   function automatic logic [31:0] i_beq(input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'b0, rs2, rs1, 3'b000, 5'b01000, 7'b1100011};
   endfunction
   function automatic logic [31:0] i_jal(input logic [4:0] rd);
      return {20'h00100, rd, 7'b1101111};
   endfunction
   function automatic logic [31:0] i_jalr(input logic [4:0] rd, input logic [4:0] rs1);
      return {12'h0, rs1, 3'b000, rd, 7'b1100111};
   endfunction

   // Builds an entry as decode would: stores and branches carry no rd
   function automatic ent_t mk(input logic [31:0] instr);
      ent_t e;
      logic [6:0] op;
      op      = instr[6:0];
      e.instr = instr;
      e.pc    = pc_ctr;
      e.imm   = pc_ctr ^ 32'h5A5A_0000;
      e.rs1   = instr[19:15];
      e.rs2   = instr[24:20];
      e.rd    = (op == 7'b0100011 || op == 7'b1100011) ? 5'd0 : instr[11:7];
      e.bp    = pc_ctr[2];
      pc_ctr  = pc_ctr + 32'd4;
      return e;
   endfunction

   function automatic bit pair_ok(input ent_t a, input ent_t b);
      bit haz, mp, c1;
      logic [6:0] oa, ob;
      oa  = a.instr[6:0];
      ob  = b.instr[6:0];
      haz = (a.rd != 5'd0) && ((b.rs1 == a.rd) || (b.rs2 == a.rd));
      mp  = (oa == 7'b0000011 || oa == 7'b0100011) && (ob == 7'b0000011 || ob == 7'b0100011);
      c1  = (oa == 7'b1100011 || oa == 7'b1101111 || oa == 7'b1100111);
      return !haz && !mp && !c1;
   endfunction

   task automatic set_in(input ent_t a, input bit va, input ent_t b, input bit vb);
      cur1 = a; cur2 = b;
      in_valid1 = va; in_valid2 = vb;
      in_instr1 = a.instr; in_instr1_imm = a.imm; in_instr1_pc = a.pc; in_instr1_bp = a.bp;
      in_instr1_rs1_address = a.rs1; in_instr1_rs2_address = a.rs2; in_instr1_rd_address = a.rd;
      in_instr2 = b.instr; in_instr2_imm = b.imm; in_instr2_pc = b.pc; in_instr2_bp = b.bp;
      in_instr2_rs1_address = b.rs1; in_instr2_rs2_address = b.rs2; in_instr2_rd_address = b.rd;
   endtask

   task automatic idle();
      ent_t z;
      z = '{default: '0};
      set_in(z, 1'b0, z, 1'b0);
   endtask

   task automatic enq2(input logic [31:0] a, input logic [31:0] b);
      ent_t ea, eb;
      ea = mk(a);
      eb = mk(b);
      set_in(ea, 1'b1, eb, 1'b1);
   endtask

   task automatic enq1(input logic [31:0] a);
      ent_t ea, z;
      ea = mk(a);
      z  = '{default: '0};
      set_in(ea, 1'b1, z, 1'b0);
   endtask

   // Called just after a falling edge with inputs applied; checks, updates model, waits a cycle
   task automatic tick();
      int unsigned sz;
      bit v1, ok2, rdy;
      ent_t h1, h2;
      #1;
      sz  = sb.size();
      v1  = (sz >= 1);
      ok2 = 1'b0;
      rdy = (sz <= DEPTH - 2);
      if (v1) h1 = sb[0];
      if (sz >= 2) begin
         h2  = sb[1];
         ok2 = pair_ok(h1, h2);
      end
      check_eq("in_ready", 32'(in_ready), 32'(rdy));
      check_eq("nop1", 32'(nop1), 32'(!v1));
      check_eq("nop2", 32'(nop2), 32'(!ok2));
      if (v1) begin
         check_eq("s1_instr", out_instr1, h1.instr);
         check_eq("s1_pc", out_instr1_pc, h1.pc);
         check_eq("s1_imm", out_instr1_imm, h1.imm);
         check_eq("s1_regs", 32'({out_instr1_rs1_address, out_instr1_rs2_address, out_instr1_rd_address}),
                  32'({h1.rs1, h1.rs2, h1.rd}));
         check_eq("s1_bp", 32'(out_instr1_bp), 32'(h1.bp));
      end else begin
         check_eq("s1_zero", out_instr1 | out_instr1_pc | out_instr1_imm, 32'd0);
      end
      if (ok2) begin
         check_eq("s2_instr", out_instr2, h2.instr);
         check_eq("s2_pc", out_instr2_pc, h2.pc);
         check_eq("s2_imm", out_instr2_imm, h2.imm);
         check_eq("s2_regs", 32'({out_instr2_rs1_address, out_instr2_rs2_address, out_instr2_rd_address}),
                  32'({h2.rs1, h2.rs2, h2.rd}));
      end else begin
         check_eq("s2_zero", out_instr2 | out_instr2_pc | out_instr2_imm, 32'd0);
      end
`ifdef ISSUE_QUEUE_PERF_EN
      check_eq("dual_cnt", dual_issue_cnt, exp_dual);
      check_eq("single_cnt", single_issue_cnt, exp_single);
`endif
      if (v1 && !stall) begin
         void'(sb.pop_front());
         if (ok2) begin
            void'(sb.pop_front());
            exp_dual++;
         end else begin
            exp_single++;
         end
      end
      if (flush_signal1 || flush_signal2)
         sb.delete();
      else if (in_valid1 && rdy) begin
         sb.push_back(cur1);
         if (in_valid2) sb.push_back(cur2);
      end
      @(negedge clk);
   endtask

   task automatic drain();
      idle();
      stall = 1'b0;
      for (int i = 0; i < 2 * DEPTH && sb.size() != 0; i++) tick();
      check_eq("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [4:0] a, b, d;
      a = 5'($urandom_range(0, 6));
      b = 5'($urandom_range(0, 6));
      d = 5'($urandom_range(0, 6));
      case ($urandom_range(0, 7))
         0, 1:    return i_addi(d, a, 12'($urandom_range(0, 4095)));
         2, 3:    return i_add(d, a, b);
         4:       return i_lw(d, a);
         5:       return i_sw(b, a);
         6:       return i_beq(a, b);
         default: return ($urandom_range(0, 1) == 0) ? i_jal(d) : i_jalr(d, a);
      endcase
   endfunction

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      rstn = 1'b0; stall = 1'b0; flush_signal1 = 1'b0; flush_signal2 = 1'b0;
      idle();
      #2;
      check_eq("rst_ready", 32'(in_ready), 32'd1);
      check_eq("rst_nop", 32'({nop1, nop2}), 32'd3);
      check_eq("rst_out", out_instr1 | out_instr2 | out_instr1_pc | out_instr2_pc, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) tick();

      // independent pair, then dependent pair
      enq2(i_addi(5'd1, 5'd0, 12'd1), i_addi(5'd2, 5'd0, 12'd2));
      tick();
      idle();
      tick();
      check_eq("pair_pc2", out_instr2_pc, 32'h0); // queue drained, slot 2 zeroed
      enq2(i_addi(5'd3, 5'd0, 12'd1), i_add(5'd4, 5'd3, 5'd3));
      tick();
      idle();
      tick();
      tick();
      tick();

      // control and memory pairing restrictions
      enq2(i_beq(5'd1, 5'd2), i_lw(5'd5, 5'd6));
      tick();
      idle();
      for (int i = 0; i < 3; i++) tick();
      enq2(i_lw(5'd7, 5'd1), i_sw(5'd2, 5'd1));
      tick();
      idle();
      for (int i = 0; i < 3; i++) tick();

      // fill to 8 under stall, drop extra, then wrap with streaming traffic
      stall = 1'b1;
      for (int i = 0; i < 4; i++) begin
         enq2(i_addi(5'(8 + i), 5'd0, 12'(i)), i_addi(5'(16 + i), 5'd0, 12'(i)));
         tick();
      end
      enq1(i_addi(5'd9, 5'd0, 12'd9));
      tick();
      stall = 1'b0;
      for (int i = 0; i < 6; i++) begin
         enq2(i_addi(5'd10, 5'd0, 12'(i)), i_addi(5'd11, 5'd0, 12'(i)));
         tick();
      end
      drain();

      // count of 7 blocks enqueue
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         enq2(i_addi(5'd12, 5'd0, 12'd1), i_addi(5'd13, 5'd0, 12'd2));
         tick();
      end
      enq1(i_addi(5'd14, 5'd0, 12'd3));
      tick();
      enq2(i_addi(5'd15, 5'd0, 12'd3), i_addi(5'd16, 5'd0, 12'd3));
      tick();
      drain();

      // flush at count 5 beats a concurrent enqueue
      stall = 1'b1;
      enq2(i_addi(5'd1, 5'd0, 12'd1), i_addi(5'd2, 5'd0, 12'd1));
      tick();
      enq2(i_addi(5'd3, 5'd0, 12'd1), i_addi(5'd4, 5'd0, 12'd1));
      tick();
      enq1(i_addi(5'd5, 5'd0, 12'd1));
      tick();
      flush_signal2 = 1'b1;
      enq2(i_addi(5'd6, 5'd0, 12'd1), i_addi(5'd7, 5'd0, 12'd1));
      tick();
      flush_signal2 = 1'b0;
      stall = 1'b0;
      idle();
      tick();
      tick();

      // mixed random traffic
      for (int i = 0; i < 250; i++) begin
         stall         = ($urandom_range(0, 3) == 0);
         flush_signal1 = ($urandom_range(0, 39) == 0);
         flush_signal2 = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 3) != 0) begin
            if ($urandom_range(0, 1) == 0) enq2(rand_instr(), rand_instr());
            else enq1(rand_instr());
         end else begin
            idle();
         end
         tick();
      end
      flush_signal1 = 1'b0;
      flush_signal2 = 1'b0;

      // asynchronous reset mid-operation
      stall = 1'b1;
      enq2(i_addi(5'd1, 5'd0, 12'd1), i_addi(5'd2, 5'd0, 12'd1));
      tick();
      idle();
      #2;
      rstn = 1'b0;
      #1;
      check_eq("arst_nop1", 32'(nop1), 32'd1);
      check_eq("arst_ready", 32'(in_ready), 32'd1);
`ifdef ISSUE_QUEUE_PERF_EN
      check_eq("arst_perf", dual_issue_cnt | single_issue_cnt, 32'd0);
`endif
      sb.delete();
      exp_dual = 0;
      exp_single = 0;
      @(negedge clk);
      rstn = 1'b1;
      stall = 1'b0;
      tick();
      enq2(i_addi(5'd3, 5'd0, 12'd1), i_addi(5'd4, 5'd0, 12'd1));
      tick();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
